// File: rtl/mul_array_pkg.sv
// Shared widths, per-beat flag bundle and extension helper
// for the SIMD multiply / multiply-accumulate array.
package mul_array_pkg;

  localparam int DEF_LANES  = 32;
  localparam int DEF_A_W    = 26;
  localparam int DEF_B_W    = 8;
  localparam int DEF_ACC_W  = 40;
  localparam int DEF_STAGES = 3;

  // Widest value the extension helper can carry
  localparam int EXT_W = 128;

  typedef struct packed {
    logic valid;
    logic sgn;
    logic acc;
    logic last;
  } stage_flags_t;

  // Extend the low w bits of v to EXT_W bits, sign or zero per sgn
  function automatic logic [EXT_W-1:0] ext(
    input logic [EXT_W-1:0] v,
    input int               w,
    input logic             sgn
  );
    logic [EXT_W-1:0] hi;
    logic [EXT_W-1:0] top;
    logic             msb;
    hi  = {EXT_W{1'b1}} << w;
    top = (hi >> 1) & ~hi;
    msb = sgn & (|(v & top));
    return msb ? (v | hi) : (v & ~hi);
  endfunction

endpackage

// File: rtl/mul_array_pipe_lane.sv
// One lane: product register, retiming delays and the
// accumulate/output register, all gated by the shared advance.
module mul_lane
  import mul_array_pkg::*;
#(
  parameter int A_W         = DEF_A_W,
  parameter int B_W         = DEF_B_W,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int PIPE_STAGES = DEF_STAGES
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             advance_i,
  input  logic             sgn_i,
  input  logic [A_W-1:0]   a_i,
  input  logic [B_W-1:0]   b_i,
  input  stage_flags_t     fin_i,
  output logic [ACC_W-1:0] p_o
);

  localparam int PW = A_W + B_W;

  logic [PW-1:0]    a_x;
  logic [PW-1:0]    b_x;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    p_fin;
  logic [ACC_W-1:0] p_ext;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] p_q;

  // Extending to the full product width first makes the
  // truncated PW-bit multiply exact for both signednesses
  assign a_x  = PW'(ext(EXT_W'(a_i), A_W, sgn_i));
  assign b_x  = PW'(ext(EXT_W'(b_i), B_W, sgn_i));
  assign prod = a_x * b_x;

  for (genvar k = 1; k < PIPE_STAGES; k++) begin : g_pipe
    logic [PW-1:0] d;
    logic [PW-1:0] q;

    if (k == 1) begin : g_head
      assign d = prod;
    end else begin : g_tail
      assign d = g_pipe[k-1].q;
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        q <= '0;
      end else if (advance_i) begin
        q <= d;
      end
    end
  end

  assign p_fin = g_pipe[PIPE_STAGES-1].q;
  assign p_ext = ACC_W'(ext(EXT_W'(p_fin), PW, fin_i.sgn));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
      p_q   <= '0;
    end else if (advance_i && fin_i.valid) begin
      unique case (1'b1)
        !fin_i.acc: begin
          p_q <= p_ext;
        end
        fin_i.acc && !fin_i.last: begin
          acc_q <= acc_q + p_ext;
        end
        fin_i.acc && fin_i.last: begin
          p_q   <= acc_q + p_ext;
          acc_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/mul_array_pipe.sv
// SIMD multiply / multiply-accumulate array with a global
// stall, valid/ready on both sides and a flag shift chain.
module mul_array_pipe
  import mul_array_pkg::*;
#(
  parameter int NUM_LANES   = DEF_LANES,
  parameter int A_W         = DEF_A_W,
  parameter int B_W         = DEF_B_W,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int PIPE_STAGES = DEF_STAGES
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       in_signed_i,
  input  logic                       in_acc_i,
  input  logic                       in_last_i,
  input  logic [NUM_LANES*A_W-1:0]   mul_a_i,
  input  logic [NUM_LANES*B_W-1:0]   mul_b_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [NUM_LANES*ACC_W-1:0] out_p_o,
  output logic                       out_last_o
);

  if (PIPE_STAGES < 2 || ACC_W < A_W + B_W ||
      ACC_W > EXT_W || A_W + B_W > EXT_W) begin : g_bad
    $error("mul_array_pipe: bad parameters");
  end

  logic         advance;
  logic         out_valid_q;
  logic         out_last_q;
  stage_flags_t in_fl;
  stage_flags_t fin;

  assign advance    = !out_valid_q || out_ready_i;
  assign in_ready_o = rst_ni && advance;

  always_comb begin
    in_fl       = '0;
    in_fl.valid = in_valid_i;
    in_fl.sgn   = in_signed_i;
    in_fl.acc   = in_acc_i;
    in_fl.last  = in_last_i && in_acc_i;
  end

  for (genvar k = 1; k < PIPE_STAGES; k++) begin : g_fl
    stage_flags_t d;
    stage_flags_t q;

    if (k == 1) begin : g_head
      assign d = in_fl;
    end else begin : g_tail
      assign d = g_fl[k-1].q;
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        q <= '0;
      end else if (advance) begin
        q <= d;
      end
    end
  end

  assign fin = g_fl[PIPE_STAGES-1].q;

  // Open accumulate beats retire without producing a result
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (advance) begin
      out_valid_q <= fin.valid && (!fin.acc || fin.last);
      out_last_q  <= fin.valid && fin.acc && fin.last;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mul_lane #(
      .A_W        (A_W),
      .B_W        (B_W),
      .ACC_W      (ACC_W),
      .PIPE_STAGES(PIPE_STAGES)
    ) u_lane (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .advance_i(advance),
      .sgn_i    (in_signed_i),
      .a_i      (mul_a_i[A_W*i +: A_W]),
      .b_i      (mul_b_i[B_W*i +: B_W]),
      .fin_i    (fin),
      .p_o      (out_p_o[ACC_W*i +: ACC_W])
    );
  end

endmodule
